// File: rtl/vxe_fifo_ram.sv
// Storage for vxe_fifo_lvl: DEPTH x DATA_WIDTH array with one synchronous write
// port and a combinational read port, so the head word falls through to the output.
module vxe_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_POW2 = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_POW2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_POW2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** DEPTH_POW2;

    // Contents are deliberately not reset; validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vxe_fifo_lvl.sv
// First-word-fall-through single-clock FIFO with registered occupancy level,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module vxe_fifo_lvl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_POW2 = 2,
    parameter int AF_THRESH  = 2 ** DEPTH_POW2 - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rd,
    output logic                  out_vld,
    output logic [DEPTH_POW2:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int PW = DEPTH_POW2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          in_rdy_q, in_rdy_d;
    logic          out_vld_q, out_vld_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          wr_acc;
    logic          rd_acc;
    logic          ovf_set;
    logic          udf_set;
    logic          ptr_full_d;
    logic          ptr_empty_d;

    // Accept decisions use only registered status, so a full FIFO never passes
    // a write through on the same cycle as a read.
    assign wr_acc  = wr & in_rdy_q  & ~flush;
    assign rd_acc  = rd & out_vld_q & ~flush;
    assign ovf_set = wr & ~in_rdy_q  & ~flush;
    assign udf_set = rd & ~out_vld_q & ~flush;

    vxe_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_POW2 (DEPTH_POW2)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[DEPTH_POW2-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[DEPTH_POW2-1:0]),
        .rdata_o (data_out)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Pointers carry one extra wrap bit, so the modular difference spans 0..DEPTH.
        level_d     = wr_ptr_d - rd_ptr_d;
        ptr_empty_d = (wr_ptr_d == rd_ptr_d);
        ptr_full_d  = (wr_ptr_d[DEPTH_POW2-1:0] == rd_ptr_d[DEPTH_POW2-1:0]) &&
                      (wr_ptr_d[DEPTH_POW2] != rd_ptr_d[DEPTH_POW2]);

        in_rdy_d  = ~ptr_full_d;
        out_vld_d = ~ptr_empty_d;
        af_d      = (level_d >= AF_L);
        ae_d      = (level_d <= AE_L);

        // A new error event outranks a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        udf_d = udf_set | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign in_rdy       = in_rdy_q;
    assign out_vld      = out_vld_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: tb/tb_vxe_fifo_lvl.sv
// Scoreboard bench for vxe_fifo_lvl: a queue-based model tracks contents, level
// and error flags; a negedge monitor compares status and pops data on each read.
module tb_vxe_fifo_lvl;

    localparam int DW    = 32;
    localparam int DP2   = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          flush;
    logic          clr_err;
    logic [DW-1:0] data_in;
    logic          wr;
    logic          in_rdy;
    logic [DW-1:0] data_out;
    logic          rd;
    logic          out_vld;
    logic [DP2:0]  level;
    logic          almost_full;
    logic          almost_empty;
    logic          ovf;
    logic          udf;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int            m_lvl = 0;
    bit            m_ovf = 0;
    bit            m_udf = 0;

    vxe_fifo_lvl #(
        .DATA_WIDTH (DW),
        .DEPTH_POW2 (DP2),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .flush        (flush),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .wr           (wr),
        .in_rdy       (in_rdy),
        .data_out     (data_out),
        .rd           (rd),
        .out_vld      (out_vld),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: occupancy is the queue size, errors follow the accept rules.
    initial begin
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                m_lvl = 0;
                m_ovf = 0;
                m_udf = 0;
                exp_q.delete();
            end else begin
                bit so, su;
                so = 0;
                su = 0;
                if (flush) begin
                    m_lvl = 0;
                    exp_q.delete();
                end else begin
                    bit wa, ra;
                    wa = wr && (m_lvl < DEPTH);
                    ra = rd && (m_lvl > 0);
                    so = wr && (m_lvl == DEPTH);
                    su = rd && (m_lvl == 0);
                    if (wa) exp_q.push_back(data_in);
                    m_lvl = m_lvl + int'(wa) - int'(ra);
                end
                m_ovf = so || (m_ovf && !clr_err);
                m_udf = su || (m_udf && !clr_err);
            end
        end
    end

    // Monitor: status every cycle, data popped from the scoreboard on each read.
    initial begin
        forever begin
            @(negedge clk);
            chk("level",        32'(level),        32'(m_lvl));
            chk("in_rdy",       32'(in_rdy),       32'(m_lvl < DEPTH));
            chk("out_vld",      32'(out_vld),      32'(m_lvl > 0));
            chk("almost_full",  32'(almost_full),  32'(m_lvl >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(m_lvl <= AE));
            chk("ovf",          32'(ovf),          32'(m_ovf));
            chk("udf",          32'(udf),          32'(m_udf));
            if (nrst && out_vld && rd && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underrun", 32'(out_vld), 32'(0));
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e);
                end
            end
        end
    end

    task automatic drive(input bit w, input bit r, input logic [DW-1:0] d,
                         input bit f = 1'b0, input bit c = 1'b0);
        wr      = w;
        rd      = r;
        data_in = d;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        {flush, clr_err, wr, rd} = '0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        // Fill to full, then one extra write.
        for (int i = 1; i <= 5; i++) drive(1, 0, 32'hBEEF_0000 + DW'(i));
        drive(0, 0, 0);
        chk("ovf_after_5th_write", 32'(ovf), 32'(1));
        chk("level_after_5th_write", 32'(level), 32'(4));

        // Drain past empty, then clear errors.
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        drive(0, 0, 0);
        chk("udf_after_5th_read", 32'(udf), 32'(1));
        drive(0, 0, 0, 0, 1);
        chk("ovf_cleared", 32'(ovf), 32'(0));
        chk("udf_cleared", 32'(udf), 32'(0));

        // Streaming at level 2 across pointer wrap.
        drive(1, 0, 32'h1111_0001);
        drive(1, 0, 32'h1111_0002);
        for (int i = 0; i < 8; i++) drive(1, 1, 32'hBEEF_BEEF);
        chk("stream_level", 32'(level), 32'(2));
        for (int i = 0; i < 2; i++) drive(0, 1, 0);

        // Empty with wr=rd=1, then full with wr=rd=1.
        drive(1, 1, 32'hA5A5_0001);
        chk("empty_wrrd_level", 32'(level), 32'(1));
        chk("empty_wrrd_udf", 32'(udf), 32'(1));
        for (int i = 2; i <= 4; i++) drive(1, 0, 32'hA5A5_0000 + DW'(i));
        drive(1, 1, 32'hA5A5_0009);
        chk("full_wrrd_level", 32'(level), 32'(3));
        chk("full_wrrd_ovf", 32'(ovf), 32'(1));
        drive(0, 0, 0, 0, 1);

        // Flush at level 3 with concurrent wr/rd.
        drive(1, 1, 32'hFEED_0000, 1);
        chk("flush_level", 32'(level), 32'(0));
        chk("flush_out_vld", 32'(out_vld), 32'(0));
        chk("flush_no_ovf", 32'(ovf), 32'(0));
        chk("flush_no_udf", 32'(udf), 32'(0));

        // Randomised traffic with occasional flush and error clear.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), DW'($urandom),
                  1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5));
        end

        // Reset asserted mid-burst takes effect without a clock edge.
        for (int i = 0; i < 3; i++) drive(1, 0, DW'($urandom));
        wr = 1'b1;
        rd = 1'b1;
        #2 nrst = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_in_rdy", 32'(in_rdy), 32'(1));
        chk("rst_out_vld", 32'(out_vld), 32'(0));
        chk("rst_almost_empty", 32'(almost_empty), 32'(1));
        chk("rst_almost_full", 32'(almost_full), 32'(0));
        @(posedge clk);
        #1;
        {wr, rd} = '0;
        nrst = 1'b1;
        drive(1, 0, 32'hC0DE_0001);
        drive(0, 1, 0);
        drive(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
